alu_seq: RTL and testbench

//   Multi-cycle, parametrised integer ALU with valid/ready handshakes on input and output.
//   - ADD and SUB complete in one cycle.
//   - MUL uses an iterative shift-add unit; DIV uses an iterative restoring divider.
//   - Successor to the combinational 4-op ALU. Sits between the operand issue stage and
//     the writeback stage; back-pressure is supported on both sides.

---
 rtl/alu_seq.sv | 194 +++++++++++++++++++
 tb/tb_alu_seq.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// alu_seq: multi-cycle unsigned ALU (single-pass add/sub, shift-add multiply, restoring divide).
// Build option: define ALU_SEQ_REM_EN to add the `remainder` output port.
module alu_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       opcode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             div_by_zero,
  output logic             busy,
  output logic [1:0]       state_dbg
`ifdef ALU_SEQ_REM_EN
  ,
  output logic [WIDTH-1:0] remainder
`endif
);

  localparam int            CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] wk_q;
  logic [WIDTH-1:0] acc_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] result_q;
  logic             dbz_q;
  logic             out_valid_q;
  logic             in_ready_q;
  logic             busy_q;
`ifdef ALU_SEQ_REM_EN
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] rem_d;
`endif

  logic [WIDTH-1:0] acc_d;
  logic [WIDTH-1:0] wk_d;
  logic [WIDTH-1:0] a_d;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   div_diff;
  logic [WIDTH-1:0] res_d;
  logic             dbz_d;
  logic             start_calc;

  // Handshakes: a transfer happens on a rising edge where valid && ready are both high.
  // in_ready is high only in IDLE; out_valid, once raised, holds with stable data until
  // the edge where out_ready is also high.
  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign result      = result_q;
  assign div_by_zero = dbz_q;
  assign busy        = busy_q;
  assign state_dbg   = state_q;
`ifdef ALU_SEQ_REM_EN
  assign remainder   = rem_q;
`endif

  assign start_calc = (opcode == OP_MUL) || ((opcode != OP_ADD) && (opcode != OP_SUB) && (b != '0));

  // One iteration step. MUL: wk holds the multiplier (LSB first), a_q the shifted
  // multiplicand. DIV: wk shifts the dividend out of its MSB and quotient bits into its LSB.
  always_comb begin
    acc_d    = acc_q;
    wk_d     = wk_q;
    a_d      = a_q;
    rem_sh   = {acc_q, wk_q[WIDTH-1]};
    div_diff = rem_sh - {1'b0, b_q};
    if (op_q == OP_MUL) begin
      acc_d = acc_q + (wk_q[0] ? a_q : '0);
      wk_d  = wk_q >> 1;
      a_d   = a_q << 1;
    end else if (!div_diff[WIDTH]) begin
      acc_d = div_diff[WIDTH-1:0];
      wk_d  = {wk_q[WIDTH-2:0], 1'b1};
    end else begin
      acc_d = rem_sh[WIDTH-1:0];
      wk_d  = {wk_q[WIDTH-2:0], 1'b0};
    end
  end

  always_comb begin
    res_d = '0;
    dbz_d = 1'b0;
`ifdef ALU_SEQ_REM_EN
    rem_d = '0;
`endif
    case (op_q)
      OP_ADD: res_d = a_q + b_q;
      OP_SUB: res_d = a_q - b_q;
      OP_MUL: res_d = acc_q;
      default: begin
        if (b_q == '0) begin
          res_d = '1;
          dbz_d = 1'b1;
`ifdef ALU_SEQ_REM_EN
          rem_d = wk_q;
`endif
        end else begin
          res_d = wk_q;
`ifdef ALU_SEQ_REM_EN
          rem_d = acc_q;
`endif
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      op_q        <= OP_ADD;
      a_q         <= '0;
      b_q         <= '0;
      wk_q        <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      result_q    <= '0;
      dbz_q       <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
`ifdef ALU_SEQ_REM_EN
      rem_q       <= '0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid && in_ready_q) begin
            op_q       <= opcode;
            a_q        <= a;
            b_q        <= b;
            wk_q       <= (opcode == OP_MUL) ? b : a;
            acc_q      <= '0;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= start_calc ? S_CALC : S_DONE;
          end
        end
        S_CALC: begin
          acc_q <= acc_d;
          wk_q  <= wk_d;
          a_q   <= a_d;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CNT_LAST) begin
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          // First DONE cycle registers the result; it then waits for the consumer.
          if (!out_valid_q) begin
            out_valid_q <= 1'b1;
            result_q    <= res_d;
            dbz_q       <= dbz_d;
`ifdef ALU_SEQ_REM_EN
            rem_q       <= rem_d;
`endif
          end else if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed + randomised bench for alu_seq (WIDTH=32) with a result scoreboard.
module tb_alu_seq;
  localparam int W = 32;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [1:0]   opcode;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         div_by_zero;
  logic         busy;
  logic [1:0]   state_dbg;
`ifdef ALU_SEQ_REM_EN
  logic [W-1:0] remainder;
`endif

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .a(a),
    .b(b),
    .opcode(opcode),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result(result),
    .div_by_zero(div_by_zero),
    .busy(busy),
    .state_dbg(state_dbg)
`ifdef ALU_SEQ_REM_EN
    ,
    .remainder(remainder)
`endif
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int           n_cmp = 0;
  int           n_fail = 0;
  int           exp_lat_g;
  logic [W-1:0] last_exp;
  logic [W-1:0] ra;
  logic [W-1:0] rb;

  // scoreboard
  logic [W-1:0] exp_q[$];
  logic         exp_dbz_q[$];
  logic [W-1:0] exp_rem_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] model_res(input logic [W-1:0] x, input logic [W-1:0] y,
                                             input logic [1:0] op);
    logic [2*W-1:0] p;
    p = (2*W)'(x) * (2*W)'(y);
    case (op)
      2'b00:   return x + y;
      2'b01:   return x - y;
      2'b10:   return p[W-1:0];
      default: return (y == '0) ? '1 : x / y;
    endcase
  endfunction

  // driver: present an operation and record what it must produce
  task automatic drive_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic [1:0] op);
    a        = x;
    b        = y;
    opcode   = op;
    in_valid = 1'b1;
    exp_q.push_back(model_res(x, y, op));
    exp_dbz_q.push_back((op == 2'b11) && (y == '0));
    exp_rem_q.push_back((op != 2'b11) ? '0 : ((y == '0) ? x : x % y));
    exp_lat_g = ((op == 2'b10) || ((op == 2'b11) && (y != '0))) ? W + 1 : 1;
  endtask

  // Called at the negedge right after the accepting edge.
  task automatic check_result(input int exp_lat, input string tag);
    int           lat;
    logic         held_off;
    logic [W-1:0] er;
    logic         ed;
    logic [W-1:0] em;
    lat      = 0;
    held_off = 1'b1;
    while (out_valid !== 1'b1 && lat < 200) begin
      if (in_ready !== 1'b0 || busy !== 1'b1) held_off = 1'b0;
      @(negedge clk);
      lat++;
    end
    chk({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    chk({tag, "_ready_low"}, 64'(held_off), 64'(1));
    er = exp_q.pop_front();
    ed = exp_dbz_q.pop_front();
    em = exp_rem_q.pop_front();
    last_exp = er;
    chk({tag, "_result"}, 64'(result), 64'(er));
    chk({tag, "_dbz"}, 64'(div_by_zero), 64'(ed));
`ifdef ALU_SEQ_REM_EN
    chk({tag, "_rem"}, 64'(remainder), 64'(em));
`endif
  endtask

  task automatic consume(input string tag);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_consumed"}, 64'(out_valid), 64'(0));
    chk({tag, "_idle_ready"}, 64'(in_ready), 64'(1));
    chk({tag, "_idle_busy"}, 64'(busy), 64'(0));
  endtask

  task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic [1:0] op,
                        input string tag);
    drive_op(x, y, op);
    @(negedge clk);
    in_valid = 1'b0;
    check_result(exp_lat_g, tag);
    consume(tag);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    opcode    = 2'b00;

    // 1: reset held with a pending request, then ADD wrap-around
    drive_op(32'hFFFF_FFFF, 32'd2, 2'b00);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'(1));
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_result", 64'(result), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_dbz", 64'(div_by_zero), 64'(0));
    rst = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    check_result(exp_lat_g, "add_wrap");
    consume("add_wrap");

    // 2-4: directed arithmetic
    run_op(32'd5, 32'd7, 2'b01, "sub_wrap");
    run_op(32'h0001_0000, 32'h0001_0003, 2'b10, "mul");
    run_op(32'd100, 32'd7, 2'b11, "div");
    run_op(32'd9, 32'd0, 2'b11, "div0");

    // 5: back-pressure after a DIV, with a competing request offered
    drive_op(32'd1000, 32'd3, 2'b11);
    @(negedge clk);
    in_valid = 1'b0;
    check_result(exp_lat_g, "bp_div");
    a        = 32'd10;
    b        = 32'd20;
    opcode   = 2'b00;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_valid_hold", 64'(out_valid), 64'(1));
      chk("bp_result_hold", 64'(result), 64'(last_exp));
      chk("bp_no_accept", 64'(in_ready), 64'(0));
    end
    drive_op(32'd10, 32'd20, 2'b00);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp_consumed", 64'(out_valid), 64'(0));
    chk("bp_not_taken_on_consume", 64'(busy), 64'(0));
    chk("bp_ready_after", 64'(in_ready), 64'(1));
    @(negedge clk);
    in_valid = 1'b0;
    check_result(exp_lat_g, "bp_add");
    consume("bp_add");

    // random operands across all opcodes, one divide by zero
    for (int i = 0; i < 8; i++) begin
      ra = $urandom;
      rb = (i == 7) ? '0 : ((i % 4 == 3) ? W'($urandom_range(1, 1000)) : $urandom);
      run_op(ra, rb, 2'(i % 4), "rand");
    end

    // 6: reset five cycles into a MUL
    drive_op(32'd1234, 32'd5678, 2'b10);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_in_ready", 64'(in_ready), 64'(1));
    chk("mid_rst_out_valid", 64'(out_valid), 64'(0));
    chk("mid_rst_result", 64'(result), 64'(0));
    chk("mid_rst_busy", 64'(busy), 64'(0));
    chk("mid_rst_dbz", 64'(div_by_zero), 64'(0));
    void'(exp_q.pop_back());
    void'(exp_dbz_q.pop_back());
    void'(exp_rem_q.pop_back());
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_rst_no_output", 64'(out_valid), 64'(0));
    run_op(32'd3, 32'd4, 2'b00, "post_rst_add");

    chk("scoreboard_empty", 64'(exp_q.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
